// File: rtl/sync_rr_arbiter.sv
// sync_rr_arbiter: synchronizes async request lines, latches rising edges and
// grants one channel at a time round-robin with done/timeout release.
module sync_rr_arbiter #(
  parameter int N = 4,
  parameter int MAX_HOLD = 255,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic [N-1:0]   async_req,
  input  logic           done,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           busy,
  output logic           timeout
);
  localparam logic [1:0] IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2;
  logic [1:0] state;
  logic [N-1:0] s1, s2, s3, pend, rise, clr;
  logic [IDW-1:0] ptr, sel, idx;
  logic [15:0] cnt;
  logic hold_exp, rel;
  assign rise = s2 & ~s3;
  assign hold_exp = cnt == 16'(MAX_HOLD - 1);
  assign rel = state == GRANT && (done || hold_exp);
  // grant is one-hot, so it doubles as the pending-clear mask on release
  assign clr = rel ? grant : '0;
  assign busy = |grant;
  always_comb begin
    sel = ptr;
    idx = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % N);
      if (pend[idx]) sel = idx;
    end
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      pend <= '0;
    end else begin
      s1 <= async_req;
      s2 <= s1;
      s3 <= s2;
      pend <= (pend & ~clr) | rise;
    end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state <= IDLE;
      grant <= '0;
      grant_id <= '0;
      ptr <= '0;
      cnt <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= rel && !done;
      if (state == IDLE && |pend) begin
        state <= GRANT;
        grant <= {{(N-1){1'b0}}, 1'b1} << sel;
        grant_id <= sel;
        cnt <= '0;
      end else if (rel) begin
        state <= GAP;
        grant <= '0;
        grant_id <= '0;
        ptr <= grant_id == IDW'(N - 1) ? '0 : grant_id + 1'b1;
      end else if (state == GRANT) begin
        cnt <= cnt == 16'hFFFF ? cnt : cnt + 16'd1;
      end else if (state != IDLE) begin
        state <= IDLE;
      end
    end
endmodule

// File: tb/tb_sync_rr_arbiter.sv
// tb_sync_rr_arbiter: directed checks of latency, round-robin order, timeout,
// done/timeout collision, set-over-clear and asynchronous reset.
module tb_sync_rr_arbiter;
  localparam int N = 4;
  localparam int MH = 5;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic done = 1'b0;
  logic [3:0] async_req = '0;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic busy, timeout;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sync_rr_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk(clk),
    .n_rst(n_rst),
    .async_req(async_req),
    .done(done),
    .grant(grant),
    .grant_id(grant_id),
    .busy(busy),
    .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_g(input string tag, input logic [3:0] g, input logic [1:0] id);
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    chk({tag, "_id"}, 32'(grant_id), 32'(id));
    chk({tag, "_busy"}, 32'(busy), 32'(|g));
  endtask

  task automatic release_done(input string tag);
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_g({tag, "_rel"}, 4'b0000, 2'd0);
    chk({tag, "_rel_to"}, 32'(timeout), 0);
    tick();
    chk_g({tag, "_gap"}, 4'b0000, 2'd0);
  endtask

  always @(negedge clk) begin
    chk("inv_onehot", 32'($onehot0(grant)), 1);
    chk("inv_busy", 32'(busy), 32'(|grant));
  end

  initial begin
    async_req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_g("rst", 4'b0000, 2'd0);
      chk("rst_to", 32'(timeout), 0);
    end
    n_rst = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk_g("rst_lat", 4'b0000, 2'd0);
    end
    tick();
    for (int c = 0; c < 4; c++) begin
      chk_g("rr", 4'(1 << c), 2'(c));
      release_done("rr");
      tick();
    end
    chk_g("rr_idle", 4'b0000, 2'd0);
    tick(3);
    chk_g("rr_idle2", 4'b0000, 2'd0);
    async_req = 4'b0000;
    tick(4);
    async_req = 4'b1001;
    tick(3);
    chk_g("wrap_wait", 4'b0000, 2'd0);
    tick();
    chk_g("wrap_first", 4'b0001, 2'd0);
    release_done("wrap0");
    tick();
    chk_g("wrap_second", 4'b1000, 2'd3);
    release_done("wrap3");
    async_req = 4'b0100;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk_g("single_lat", 4'b0000, 2'd0);
    end
    tick();
    chk_g("single_e4", 4'b0100, 2'd2);
    tick(4);
    chk_g("single_e8", 4'b0100, 2'd2);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_g("collide_rel", 4'b0000, 2'd0);
    chk("collide_to", 32'(timeout), 0);
    tick();
    chk("collide_to2", 32'(timeout), 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_g("single_hold", 4'b0000, 2'd0);
    end
    async_req = 4'b0000;
    tick(4);
    async_req = 4'b0110;
    tick();
    async_req = 4'b0000;
    tick(2);
    chk_g("to_wait", 4'b0000, 2'd0);
    tick();
    chk_g("to_grant", 4'b0010, 2'd1);
    for (int k = 1; k < MH; k++) begin
      tick();
      chk_g("to_hold", 4'b0010, 2'd1);
      chk("to_hold_to", 32'(timeout), 0);
    end
    tick();
    chk_g("to_rel", 4'b0000, 2'd0);
    chk("to_pulse", 32'(timeout), 1);
    tick();
    chk_g("to_gap", 4'b0000, 2'd0);
    chk("to_pulse_end", 32'(timeout), 0);
    async_req = 4'b0100;
    tick();
    chk_g("to_next", 4'b0100, 2'd2);
    release_done("setclr");
    tick();
    chk_g("setclr_regrant", 4'b0100, 2'd2);
    release_done("setclr2");
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_g("to_pend_clr", 4'b0000, 2'd0);
    end
    async_req = 4'b0010;
    tick(4);
    chk_g("mid_grant", 4'b0010, 2'd1);
    tick();
    #2;
    n_rst = 1'b0;
    #1;
    chk_g("mid_rst", 4'b0000, 2'd0);
    chk("mid_rst_to", 32'(timeout), 0);
    async_req = 4'b1001;
    #2;
    n_rst = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk_g("mid_lat", 4'b0000, 2'd0);
    end
    tick();
    chk_g("mid_ptr0", 4'b0001, 2'd0);
    release_done("mid0");
    tick();
    chk_g("mid_next", 4'b1000, 2'd3);
    release_done("mid3");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
